// File: rtl/minterm_scanner_if.sv
// Handshake and result bundle between the truth-table scanner and its requester.
// The name truth_table stands in for "table", which is a reserved word.
interface minterm_scanner_if;
    logic        start;
    logic        ack;
    logic        f_in;
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  ones;

    modport master (
        output start, ack, f_in,
        input  vec, busy, done, truth_table, ones
    );

    modport slave (
        input  start, ack, f_in,
        output vec, busy, done, truth_table, ones
    );
endinterface

// File: rtl/minterm_scanner.sv
// Walks a 4-input function through all 16 input vectors and captures its truth table.
//   state | meaning
//   IDLE  | vec parked at 0, results held, waiting for start
//   DRIVE | presenting vec, sampling f_in once per vector after SETTLE extra cycles
//   DONE  | results and vec=15 held until ack
module minterm_scanner #(
    parameter int SETTLE = 0
) (
    input  logic               clk,
    input  logic               rst,
    minterm_scanner_if.slave   bus
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  vec_q;
    logic [3:0]  settle_cnt;
    logic [15:0] table_q;
    logic [4:0]  ones_q;
    logic        sample_now;
    logic        busy_c, done_c;

    assign sample_now = (state == DRIVE) && (settle_cnt == SETTLE_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DRIVE;
            DRIVE:   if (sample_now && vec_q == 4'hF) state_nxt = DONE;
            DONE:    if (bus.ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == DRIVE);
        done_c = (state == DONE);
    end

    // f_in is only looked at on the edge where the settle count reaches SETTLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q      <= 4'h0;
            settle_cnt <= 4'h0;
            table_q    <= 16'h0000;
            ones_q     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        vec_q      <= 4'h0;
                        settle_cnt <= 4'h0;
                        table_q    <= 16'h0000;
                        ones_q     <= 5'd0;
                    end
                end
                DRIVE: begin
                    if (!sample_now) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end else begin
                        table_q[vec_q] <= bus.f_in;
                        ones_q         <= ones_q + {4'b0000, bus.f_in};
                        settle_cnt     <= 4'h0;
                        if (vec_q != 4'hF) vec_q <= vec_q + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.ack) vec_q <= 4'h0;
                end
                default: vec_q <= 4'h0;
            endcase
        end
    end

    assign bus.vec         = vec_q;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.truth_table = table_q;
    assign bus.ones        = ones_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner at SETTLE = 0, 3 and 2.
module tb_minterm_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [1:0] f_mode = 2'd0;   // 0: reference function, 1: tie high, 2: tie low
    logic f2 = 1'b0;

    always #5 clk = ~clk;

    minterm_scanner_if bus0 ();
    minterm_scanner_if bus3 ();
    minterm_scanner_if bus2 ();

    minterm_scanner #(.SETTLE(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    minterm_scanner #(.SETTLE(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));
    minterm_scanner #(.SETTLE(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic logic fref(input logic [3:0] v);
        return (v[2] & ~v[1]) | (v[3] & v[2]) | (~v[1] & v[0]);
    endfunction

    assign bus0.f_in = (f_mode == 2'd1) ? 1'b1 : (f_mode == 2'd2) ? 1'b0 : fref(bus0.vec);
    assign bus3.f_in = fref(bus3.vec);
    assign bus2.f_in = f2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan0(output int lat);
        @(negedge clk) bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        lat = 0;
        while (!bus0.done && lat < 200) begin
            @(posedge clk); lat++; #1;
        end
    endtask

    task automatic ack0();
        @(negedge clk) bus0.ack = 1'b1;
        @(negedge clk) bus0.ack = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int vec_bad;
        logic [15:0] tbl_snap;

        bus0.start = 0; bus0.ack = 0;
        bus3.start = 0; bus3.ack = 0;
        bus2.start = 0; bus2.ack = 0;

        #3;
        check("rst_vec", 32'(bus0.vec), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_done", 32'(bus0.done), 0);
        check("rst_table", 32'(bus0.truth_table), 0);
        check("rst_ones", 32'(bus0.ones), 0);

        @(negedge clk) rst = 1'b0;
        bus0.ack = 1'b1;               // ack outside DONE is ignored
        repeat (3) @(negedge clk);
        bus0.ack = 1'b0;
        check("idle_stays_busy", 32'(bus0.busy), 0);
        check("idle_stays_done", 32'(bus0.done), 0);

        // Reference function, SETTLE=0
        scan0(lat);
        check("s0_latency", 32'(lat), 16);
        check("s0_table", 32'(bus0.truth_table), 32'h0000_F232);
        check("s0_ones", 32'(bus0.ones), 8);
        check("s0_vec_done", 32'(bus0.vec), 15);
        check("s0_busy_done", 32'(bus0.busy), 0);
        f_mode = 2'd1;                 // f_in changes while DONE must not matter
        repeat (3) @(negedge clk);
        check("s0_hold_table", 32'(bus0.truth_table), 32'h0000_F232);
        check("s0_hold_vec", 32'(bus0.vec), 15);
        check("s0_hold_done", 32'(bus0.done), 1);
        ack0();
        check("s0_ack_vec", 32'(bus0.vec), 0);
        check("s0_ack_done", 32'(bus0.done), 0);
        check("s0_ack_keep", 32'(bus0.truth_table), 32'h0000_F232);

        // Tied inputs
        scan0(lat);
        check("tie1_table", 32'(bus0.truth_table), 32'h0000_FFFF);
        check("tie1_ones", 32'(bus0.ones), 16);
        ack0();
        f_mode = 2'd2;
        scan0(lat);
        check("tie0_table", 32'(bus0.truth_table), 0);
        check("tie0_ones", 32'(bus0.ones), 0);
        ack0();
        f_mode = 2'd0;

        // start during DRIVE and DONE ignored, ack wins over start
        @(negedge clk) bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        n = 0;
        while (!bus0.done && n < 200) begin
            @(posedge clk); n++; #1;
            if (n == 5) bus0.start = 1'b1;
            if (n == 6) bus0.start = 1'b0;
        end
        check("drv_start_latency", 32'(n), 16);
        check("drv_start_table", 32'(bus0.truth_table), 32'h0000_F232);
        bus0.start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("done_start_done", 32'(bus0.done), 1);
        check("done_start_busy", 32'(bus0.busy), 0);
        check("done_start_vec", 32'(bus0.vec), 15);
        bus0.ack = 1'b1;
        @(posedge clk); #1;
        check("ackstart_done", 32'(bus0.done), 0);
        check("ackstart_busy", 32'(bus0.busy), 0);
        check("ackstart_vec", 32'(bus0.vec), 0);
        bus0.ack = 1'b0; bus0.start = 1'b0;
        @(posedge clk); #1;
        check("ackstart_noqueue", 32'(bus0.busy), 0);
        check("ackstart_keep", 32'(bus0.truth_table), 32'h0000_F232);

        // Async reset mid-scan
        @(negedge clk) bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        n = 0;
        while (bus0.vec != 4'd7 && n < 50) begin
            @(posedge clk); n++; #1;
        end
        check("mid_vec7_reached", 32'(bus0.vec), 7);
        check("mid_partial_ones", 32'(bus0.ones), 3);
        #2 rst = 1'b1;
        #1;
        check("arst_vec", 32'(bus0.vec), 0);
        check("arst_busy", 32'(bus0.busy), 0);
        check("arst_table", 32'(bus0.truth_table), 0);
        check("arst_ones", 32'(bus0.ones), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(bus0.busy), 0);
        scan0(lat);
        check("post_rst_latency", 32'(lat), 16);
        check("post_rst_table", 32'(bus0.truth_table), 32'h0000_F232);
        check("post_rst_ones", 32'(bus0.ones), 8);
        ack0();

        // SETTLE=3: each vector held four cycles
        @(negedge clk) bus3.start = 1'b1;
        @(posedge clk); #1 bus3.start = 1'b0;
        n = 0; vec_bad = 0;
        while (!bus3.done && n < 300) begin
            @(posedge clk); n++; #1;
            if (bus3.vec != ((n >= 64) ? 4'd15 : 4'(n / 4))) vec_bad++;
        end
        check("s3_latency", 32'(n), 64);
        check("s3_vec_hold", 32'(vec_bad), 0);
        check("s3_table", 32'(bus3.truth_table), 32'h0000_F232);
        check("s3_ones", 32'(bus3.ones), 8);
        @(negedge clk) bus3.ack = 1'b1;
        @(negedge clk) bus3.ack = 1'b0;
        check("s3_ack_idle", 32'(bus3.done), 0);

        // SETTLE=2: f_in correct only on the sample edge, inverted otherwise
        @(negedge clk) bus2.start = 1'b1;
        @(posedge clk); #1 bus2.start = 1'b0;
        n = 0;
        f2 = ~fref(4'd0);
        while (!bus2.done && n < 300) begin
            @(posedge clk); n++; #1;
            f2 = (((n + 1) % 3) == 0) ? fref(4'(n / 3)) : ~fref(4'(n / 3));
        end
        check("s2_latency", 32'(n), 48);
        check("s2_table", 32'(bus2.truth_table), 32'h0000_F232);
        check("s2_ones", 32'(bus2.ones), 8);
        tbl_snap = bus2.truth_table;
        repeat (2) begin @(negedge clk) f2 = ~f2; end
        check("s2_done_stable", 32'(bus2.truth_table), 32'(tbl_snap));
        check("s2_excl", 32'({bus2.busy, bus2.done}), 32'b01);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/minterm_scanner.md
MINTERM_SCANNER -- requirements
Module: minterm_scanner

Interface
REQ-001 Parameter SETTLE, default 0, legal range 0..15: extra wait cycles per input vector before f_in is sampled.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a full truth-table scan; honoured only in IDLE.
REQ-005 ack  input  1  consumer acknowledge of a finished scan; honoured only in DONE.
REQ-006 f_in  input  1  output of the external 4-input combinational function under test, driven from vec.
REQ-007 vec  output  4  registered input vector to the function; vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d.
REQ-008 busy  output  1  high while a scan is in progress (DRIVE state).
REQ-009 done  output  1  high while results are held (DONE state).
REQ-010 table  output  16  captured truth table; table[k] = f_in observed with vec==k.
REQ-011 ones  output  5  count of set bits in table (number of minterms), 0..16.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DRIVE, DONE.
REQ-013 IDLE: vec=0, busy=0, done=0; table and ones hold their last values.
REQ-014 IDLE with start=1 at an edge: go to DRIVE; clear table to 0, ones to 0, vec to 0, settle counter to 0.
REQ-015 DRIVE: busy=1; if the settle counter < SETTLE, increment it and hold vec.
REQ-016 DRIVE, settle counter == SETTLE: at that edge, write f_in into table[vec], add f_in to ones, and reset the settle counter to 0.
REQ-017 At the same edge, if vec<15, increment vec; if vec==15, go to DONE and hold vec at 15.
REQ-018 Scan latency SHALL be exactly 16*(SETTLE+1) cycles from the start-accept edge to done rising.
REQ-019 f_in SHALL be sampled only at the REQ-016 edges; changes on f_in at any other time SHALL have no effect.
REQ-020 DONE: done=1, busy=0; table, ones and vec held stable until ack.
REQ-021 DONE with ack=1: go to IDLE at that edge (vec returns to 0); table and ones retained.
REQ-022 start while in DRIVE or DONE SHALL be ignored and not queued; ack outside DONE SHALL be ignored.
REQ-023 start and ack both high in DONE: ack wins; go to IDLE; start not accepted that cycle.
REQ-024 start held high continuously: a new scan starts on the first edge in IDLE; back-to-back scans need start high after ack.
REQ-025 ones SHALL never wrap: 16 set bits give ones=16 (5'b10000).
REQ-026 busy and done SHALL never be high at the same time.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, independent of clk: vec=0, busy=0, done=0, table=16'h0000, ones=0, settle counter 0.
REQ-028 rst asserted during DRIVE or DONE SHALL abort the scan; no partial table is retained.
REQ-029 After rst deasserts, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-030 SETTLE=0; f_in driven by f = b&~c | a&b | ~c&d from vec; pulse start -> done after 16 cycles, table=16'hF232, ones=8.
REQ-031 SETTLE=3, same function -> done after 64 cycles, vec holds each value 4 cycles, table=16'hF232, ones=8.
REQ-032 f_in tied 1 -> table=16'hFFFF, ones=16; f_in tied 0 -> table=16'h0000, ones=0.
REQ-033 start pulsed at cycle 5 of DRIVE and again in DONE -> no restart; ack+start together in DONE -> IDLE, no new scan.
REQ-034 rst asserted asynchronously mid-scan (vec=7) -> outputs immediately 0; a new start gives a clean full scan with the REQ-030 result.
REQ-035 f_in toggled between sample edges with SETTLE=2 -> table reflects only the values at the sample edges.
